// File: rtl/stu_pkg.sv
// Shared types and constants for the serial conditional-skip test unit.
package stu_pkg;

    localparam logic [5:0] STU_SKN  = 6'b000011;
    localparam logic [5:0] STU_SKZ  = 6'b000111;
    localparam logic [5:0] STU_SKP  = 6'b001011;
    localparam logic [5:0] STU_SKNZ = 6'b001111;

    localparam logic [1:0] CI_INC_ONE = 2'b01;
    localparam logic [1:0] CI_INC_TWO = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_HOLD
    } state_e;

    typedef enum logic [1:0] {
        MODE_SKN,
        MODE_SKZ,
        MODE_SKP,
        MODE_SKNZ
    } mode_e;

    function automatic logic eval_test(
        input mode_e m,
        input logic  sign,
        input logic  nonzero
    );
        logic r;
        r = 1'b0;
        unique case (m)
            MODE_SKN:  r = sign;
            MODE_SKZ:  r = ~nonzero;
            MODE_SKP:  r = ~sign & nonzero;
            MODE_SKNZ: r = nonzero;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/beat_digit_counter.sv
// Digit index within the current beat; flags the strobe carrying the last digit.
module beat_digit_counter #(
    parameter int LINE_LENGTH = 40
) (
    input  logic                           w_CLK,
    input  logic                           w_RESET,
    input  logic                           w_DIGIT,
    input  logic                           w_BEAT_START,
    output logic [$clog2(LINE_LENGTH)-1:0] b_COUNT,
    output logic                           w_LAST_DIGIT
);

    localparam int CW = $clog2(LINE_LENGTH);
    localparam logic [CW-1:0] LAST = CW'(LINE_LENGTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // cnt_d is the index of the digit presented by the current strobe
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (w_BEAT_START) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge w_CLK or posedge w_RESET) begin
        if (w_RESET) begin
            cnt_q <= '0;
        end else if (w_DIGIT) begin
            cnt_q <= cnt_d;
        end
    end

    assign b_COUNT      = cnt_q;
    assign w_LAST_DIGIT = w_DIGIT & (cnt_d == LAST);

endmodule

// File: rtl/serial_test_unit.sv
// Conditional-skip test unit: samples the accumulator over an action beat,
// holds the verdict through the scan beat and steers the CI increment.
module serial_test_unit
    import stu_pkg::*;
#(
    parameter int LINE_LENGTH         = 40,
    parameter int INSTR_FUNCTION_BITS = 6,
    parameter logic [INSTR_FUNCTION_BITS-1:0] INST_SKN  = INSTR_FUNCTION_BITS'(STU_SKN),
    parameter logic [INSTR_FUNCTION_BITS-1:0] INST_SKZ  = INSTR_FUNCTION_BITS'(STU_SKZ),
    parameter logic [INSTR_FUNCTION_BITS-1:0] INST_SKP  = INSTR_FUNCTION_BITS'(STU_SKP),
    parameter logic [INSTR_FUNCTION_BITS-1:0] INST_SKNZ = INSTR_FUNCTION_BITS'(STU_SKNZ)
) (
    input  logic                           w_CLK,
    input  logic                           w_RESET,
    input  logic                           w_DIGIT,
    input  logic                           w_BEAT_START,
    input  logic                           w_ACTION,
    input  logic [INSTR_FUNCTION_BITS-1:0] b_FST,
    input  logic                           w_A_SERIAL,
    output logic                           w_TEST_PASS,
    output logic [1:0]                     b_CI_INC,
    output logic                           w_BUSY,
    output logic [$clog2(LINE_LENGTH)-1:0] b_DIGIT_COUNT
);

    state_e state_q, state_d;
    mode_e  mode_q, mode_d;
    logic   nz_q, nz_d;
    logic   pass_q, pass_d;

    logic   last_digit;
    logic   is_test;
    mode_e  fst_mode;
    logic   start;
    logic   nz_cur;

    beat_digit_counter #(
        .LINE_LENGTH(LINE_LENGTH)
    ) u_cnt (
        .w_CLK       (w_CLK),
        .w_RESET     (w_RESET),
        .w_DIGIT     (w_DIGIT),
        .w_BEAT_START(w_BEAT_START),
        .b_COUNT     (b_DIGIT_COUNT),
        .w_LAST_DIGIT(last_digit)
    );

    always_comb begin
        is_test  = 1'b1;
        fst_mode = MODE_SKN;
        if (b_FST == INST_SKN) begin
            fst_mode = MODE_SKN;
        end else if (b_FST == INST_SKZ) begin
            fst_mode = MODE_SKZ;
        end else if (b_FST == INST_SKP) begin
            fst_mode = MODE_SKP;
        end else if (b_FST == INST_SKNZ) begin
            fst_mode = MODE_SKNZ;
        end else begin
            is_test = 1'b0;
        end
    end

    assign start  = w_DIGIT & w_BEAT_START & w_ACTION & is_test;
    assign nz_cur = nz_q | w_A_SERIAL;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        nz_d    = nz_q;
        pass_d  = pass_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SAMPLE;
                    mode_d  = fst_mode;
                    nz_d    = w_A_SERIAL;
                end
            end
            ST_SAMPLE: begin
                if (w_DIGIT) begin
                    if (w_BEAT_START) begin
                        // a new beat before the sign digit discards the partial test
                        pass_d  = 1'b0;
                        state_d = start ? ST_SAMPLE : ST_IDLE;
                        mode_d  = start ? fst_mode : mode_q;
                        nz_d    = start ? w_A_SERIAL : 1'b0;
                    end else begin
                        nz_d = nz_cur;
                        if (last_digit) begin
                            pass_d  = eval_test(mode_q, w_A_SERIAL, nz_cur);
                            state_d = ST_HOLD;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (w_DIGIT) begin
                    if (w_BEAT_START & w_ACTION) begin
                        pass_d  = 1'b0;
                        state_d = start ? ST_SAMPLE : ST_IDLE;
                        mode_d  = start ? fst_mode : mode_q;
                        nz_d    = start ? w_A_SERIAL : 1'b0;
                    end else if (last_digit & ~w_ACTION) begin
                        pass_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pass_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge w_CLK or posedge w_RESET) begin
        if (w_RESET) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_SKN;
            nz_q    <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            nz_q    <= nz_d;
            pass_q  <= pass_d;
        end
    end

    assign w_TEST_PASS = pass_q;
    assign b_CI_INC    = pass_q ? CI_INC_TWO : CI_INC_ONE;
    assign w_BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_test_unit.sv
// Randomized scoreboard bench for serial_test_unit (LINE_LENGTH 40 and 32).
module tb_serial_test_unit;

    localparam int L  = 40;
    localparam int L2 = 32;

    localparam logic [5:0] C_SKN  = 6'b000011;
    localparam logic [5:0] C_SKZ  = 6'b000111;
    localparam logic [5:0] C_SKP  = 6'b001011;
    localparam logic [5:0] C_SKNZ = 6'b001111;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       dig, bs, act, a;
    logic [5:0] fst;
    logic       pass, busy;
    logic [1:0] ci;
    logic [5:0] cnt;

    logic       dig2, bs2, act2, a2;
    logic [5:0] fst2;
    logic       pass2, busy2;
    logic [1:0] ci2;
    logic [4:0] cnt2;

    serial_test_unit #(.LINE_LENGTH(L)) dut (
        .w_CLK(clk), .w_RESET(rst), .w_DIGIT(dig), .w_BEAT_START(bs),
        .w_ACTION(act), .b_FST(fst), .w_A_SERIAL(a),
        .w_TEST_PASS(pass), .b_CI_INC(ci), .w_BUSY(busy),
        .b_DIGIT_COUNT(cnt)
    );

    serial_test_unit #(.LINE_LENGTH(L2)) dut32 (
        .w_CLK(clk), .w_RESET(rst), .w_DIGIT(dig2), .w_BEAT_START(bs2),
        .w_ACTION(act2), .b_FST(fst2), .w_A_SERIAL(a2),
        .w_TEST_PASS(pass2), .b_CI_INC(ci2), .w_BUSY(busy2),
        .b_DIGIT_COUNT(cnt2)
    );

    typedef struct packed {
        logic       pass;
        logic [1:0] ci;
        logic       busy;
        logic [5:0] cnt;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   holding = 1'b0;
    bit   held = 1'b0;

    function automatic bit is_test(input logic [5:0] f);
        return (f == C_SKN) || (f == C_SKZ) || (f == C_SKP) || (f == C_SKNZ);
    endfunction

    function automatic bit ref_result(input logic [5:0] f, input logic [L-1:0] acc);
        bit neg, zero;
        neg  = acc[L-1];
        zero = (acc == '0);
        if (f == C_SKN) return neg;
        if (f == C_SKZ) return zero;
        if (f == C_SKP) return !neg && !zero;
        if (f == C_SKNZ) return !zero;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic noise();
        bs  = 1'($urandom);
        a   = 1'($urandom);
        act = 1'($urandom);
        fst = 6'($urandom);
    endtask

    task automatic strobe(input bit b, input bit ac, input bit d, input logic [5:0] f, input exp_t e);
        @(negedge clk);
        dig = 1'b1;
        bs  = b;
        act = ac;
        a   = d;
        fst = f;
        sbq.push_back(e);
        @(negedge clk);
        dig = 1'b0;
        noise();
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            noise();
        end
    endtask

    task automatic run_beat(input logic [5:0] f, input bit action, input logic [L-1:0] acc, input int n);
        bit   samp, r;
        exp_t e;
        samp = action && is_test(f);
        r    = ref_result(f, acc);
        for (int i = 0; i < n; i++) begin
            e.cnt = 6'(i);
            if (samp) begin
                e.busy = 1'b1;
                e.pass = (i == L - 1) ? r : 1'b0;
            end else if (holding && !action) begin
                e.busy = (i != L - 1);
                e.pass = (i != L - 1) ? held : 1'b0;
            end else begin
                e.busy = 1'b0;
                e.pass = 1'b0;
            end
            e.ci = e.pass ? 2'b10 : 2'b01;
            strobe(i == 0, action, acc[i], (i == 0) ? f : 6'($urandom), e);
        end
        holding = samp && (n == L);
        held    = r;
    endtask

    task automatic scan();
        run_beat(6'($urandom), 1'b0, {$urandom, $urandom}, L);
    endtask

    task automatic beat2(input logic [5:0] f, input bit action, input logic [L2-1:0] acc);
        for (int i = 0; i < L2; i++) begin
            @(negedge clk);
            dig2 = 1'b1;
            bs2  = (i == 0);
            act2 = action;
            a2   = acc[i];
            fst2 = f;
            @(negedge clk);
            dig2 = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (dig === 1'b1 && rst === 1'b0) begin
                @(negedge clk);
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL monitor: unexpected strobe, no expectation queued");
                end else begin
                    exp_t e, g;
                    e = sbq.pop_front();
                    g = {pass, ci, busy, cnt};
                    n_cmp++;
                    if (g !== e) begin
                        n_bad++;
                        $display("FAIL digit: got pass=%b ci=%b busy=%b cnt=%0d expected pass=%b ci=%b busy=%b cnt=%0d",
                                 g.pass, g.ci, g.busy, g.cnt, e.pass, e.ci, e.busy, e.cnt);
                    end
                end
            end
        end
    end

    initial begin
        logic [L-1:0] acc;
        logic [5:0]   f;
        int           n;
        rst = 1'b1;
        {dig, bs, act, a, fst} = '0;
        {dig2, bs2, act2, a2, fst2} = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", {pass, ci, busy, cnt}, {1'b0, 2'b01, 1'b0, 6'd0});
        chk("reset_state32", {pass2, ci2, busy2, cnt2}, {1'b0, 2'b01, 1'b0, 5'd0});
        rst = 1'b0;

        run_beat(C_SKN, 1'b1, 40'h80_0000_0000, L); scan();
        run_beat(C_SKZ, 1'b1, 40'h0, L);            scan();
        run_beat(C_SKZ, 1'b1, 40'h1, L);            scan();
        run_beat(C_SKP, 1'b1, 40'h5, L);            scan();
        run_beat(C_SKP, 1'b1, 40'h0, L);            scan();
        run_beat(C_SKNZ, 1'b1, 40'h80_0000_0000, L); scan();
        run_beat(6'b100000, 1'b1, 40'h80_0000_0001, L); scan();
        run_beat(C_SKN, 1'b1, 40'hFF_FFFF_FFFF, 20);
        run_beat(C_SKN, 1'b1, 40'h80_1234_5678, L); scan();
        run_beat(C_SKN, 1'b1, 40'h80_0000_0000, L);
        run_beat(C_SKZ, 1'b1, 40'h0, L);            scan();

        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 5))
                0: f = C_SKN;
                1: f = C_SKZ;
                2: f = C_SKP;
                3: f = C_SKNZ;
                default: f = 6'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: acc = '0;
                1: acc = 40'h80_0000_0000;
                2: acc = 40'(1) << $urandom_range(0, L - 2);
                default: acc = {$urandom, $urandom};
            endcase
            n = L;
            if ($urandom_range(0, 4) == 0) n = $urandom_range(1, L - 1);
            if ($urandom_range(0, 2) == 0) scan();
            else run_beat(f, 1'b1, acc, n);
        end

        run_beat(C_SKN, 1'b1, 40'h80_0000_0001, L);
        @(negedge clk);
        chk("hold_before_reset", {pass, ci, busy}, {1'b1, 2'b10, 1'b1});
        rst = 1'b1;
        #1;
        chk("async_reset", {pass, ci, busy, cnt}, {1'b0, 2'b01, 1'b0, 6'd0});
        @(negedge clk);
        rst = 1'b0;
        holding = 1'b0;
        run_beat(C_SKP, 1'b1, 40'h7F_0000_0000, L); scan();

        beat2(C_SKN, 1'b1, 32'h8000_0000);
        chk("l32_skn_pass", {pass2, ci2, busy2, cnt2}, {1'b1, 2'b10, 1'b1, 5'd31});
        beat2(C_SKN, 1'b0, 32'h1234_5678);
        chk("l32_scan_release", {pass2, ci2, busy2}, {1'b0, 2'b01, 1'b0});
        beat2(C_SKN, 1'b1, 32'h4000_0000);
        chk("l32_skn_fail", {pass2, ci2, busy2}, {1'b0, 2'b01, 1'b1});

        repeat (3) @(negedge clk);
        chk("queue_drained", 16'(sbq.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_test_unit.md
# serial_test_unit

Parametrised conditional-skip test unit for the serial machine. During an action beat it watches the accumulator's serial output digit by digit and evaluates one of four test conditions selected by the function staticisor. It then holds the result through the following scan beat, and steers the control-instruction increment: +1 normally, +2 when the test passes. It generalises the single-mode "skip if negative" test unit to any line length, adds zero and positive tests, and adds explicit beat sequencing with abort handling.

## Interface
Parameters:
- `LINE_LENGTH`, 40: digits per line. Sign is the last digit, LSB first.
- `INSTR_FUNCTION_BITS`, 6: width of the function code.
- `INST_SKN`, 6'b000011: skip if accumulator negative.
- `INST_SKZ`, 6'b000111: skip if accumulator zero.
- `INST_SKP`, 6'b001011: skip if accumulator positive and non-zero.
- `INST_SKNZ`, 6'b001111: skip if accumulator non-zero.

Ports:
- `w_CLK`, in, 1: single system clock; all state changes on its rising edge.
- `w_RESET`, in, 1: asynchronous, active-high reset.
- `w_DIGIT`, in, 1: digit strobe, one clock wide, once per serial digit period.
- `w_BEAT_START`, in, 1: qualifies `w_DIGIT` as digit 0 of a beat.
- `w_ACTION`, in, 1: high for the whole action beat, low during scan beats.
- `b_FST`, in, `INSTR_FUNCTION_BITS`: current function code.
- `w_A_SERIAL`, in, 1: accumulator serial output, valid when `w_DIGIT`.
- `w_TEST_PASS`, out, 1: latched test result.
- `b_CI_INC`, out, 2: CI increment select. 2'b01 means +1; 2'b10 means +2.
- `w_BUSY`, out, 1: high in SAMPLE or HOLD.
- `b_DIGIT_COUNT`, out, `$clog2(LINE_LENGTH)`: current digit index.

## Operation
- Digit counter: on `w_DIGIT & w_BEAT_START` it loads 0. On any other `w_DIGIT` it increments, wrapping from `LINE_LENGTH-1` to 0. It holds between strobes.
- Mode decode: `b_FST` is compared with the four `INST_*` codes and captured into a mode register at sampling start. Later `b_FST` changes are ignored.
- IDLE:
  - Condition: `w_DIGIT & w_BEAT_START & w_ACTION` and `b_FST` matches a test code.
  - Action: enter SAMPLE, capture the mode, set `nonzero <= w_A_SERIAL`.
  - Any other code: stay in IDLE with `w_TEST_PASS` = 0.
- SAMPLE:
  - On each `w_DIGIT`: `nonzero <= nonzero | w_A_SERIAL`.
  - On the digit at index `LINE_LENGTH-1`: sign = `w_A_SERIAL`. Evaluate the test using the OR including the current bit:
    - SKN: sign.
    - SKZ: !nonzero.
    - SKP: !sign & nonzero.
    - SKNZ: nonzero.
  - Load `w_TEST_PASS` with the result and enter HOLD.
- HOLD:
  - `w_TEST_PASS` is held.
  - On `w_DIGIT` at index `LINE_LENGTH-1` with `w_ACTION` low (end of the scan beat): clear `w_TEST_PASS` and enter IDLE.
- `b_CI_INC` = `w_TEST_PASS ? 2'b10 : 2'b01`. It is combinational from the register and never 2'b00 or 2'b11.
- Abort:
  - `w_DIGIT & w_BEAT_START` in SAMPLE before the last digit discards the partial result. It re-enters SAMPLE if the restart conditions hold, otherwise IDLE. `w_TEST_PASS` stays 0.
  - `w_BEAT_START` with `w_ACTION` high while in HOLD starts a fresh SAMPLE (back-to-back test instructions). `w_TEST_PASS` is cleared on that edge.
- A `w_RESET` assertion mid-operation abandons any sample immediately.

## Timing
- Reset values: state IDLE, `w_TEST_PASS` 0, `b_CI_INC` 2'b01, `w_BUSY` 0, `b_DIGIT_COUNT` 0, mode and `nonzero` 0.
- Result latency: `w_TEST_PASS` is valid on the rising edge that consumes the last digit of the action beat, one clock after that strobe is sampled.
- Hold duration: the result remains stable until the edge consuming the last digit of the next non-action beat.
- Strobe gating: clocks without `w_DIGIT` change nothing except asynchronous reset.
- Precedence: `w_RESET` > abort/restart > normal transition.

## Structure
- Shared package `stu_pkg`:
  - `INST_*` defaults.
  - State enum: IDLE, SAMPLE, HOLD.
  - Mode enum: SKN, SKZ, SKP, SKNZ.
  - `CI_INC_ONE` / `CI_INC_TWO` constants.
- Sub-module `beat_digit_counter`: parameter `LINE_LENGTH`. Inputs `w_CLK`, `w_RESET`, `w_DIGIT`, `w_BEAT_START`. Outputs the count and `w_LAST_DIGIT`. The FSM, mode decode and evaluation stay in the top level.

## Test plan
- LINE_LENGTH=40, SKN, accumulator 0x8000000000 (only bit 39 set) -> `w_TEST_PASS`=1 and `b_CI_INC`=2'b10 after digit 39. Both return to 0 / 2'b01 after digit 39 of the next scan beat.
- SKZ, all-zero accumulator -> pass=1. Repeat with only bit 0 set -> pass=0 and `b_CI_INC`=2'b01.
- SKP with 0x0000000005 -> pass=1. SKP with 0 -> pass=0. SKNZ with 0x8000000000 -> pass=1.
- Non-test code 6'b100000 in the action beat -> `w_BUSY` stays 0, `b_CI_INC`=2'b01 throughout.
- Beat restart at digit 20 of SKN sampling -> no pass from the partial beat. Next full beat with sign 1 -> pass=1.
- Assert `w_RESET` during HOLD with pass=1 -> pass=0, IDLE, count 0 immediately (asynchronous). Re-run with LINE_LENGTH=32, SKN, bit 31 set -> pass=1.
